// File: rtl/cache_pkg.sv
// Shared types and default widths for the single-entry cache line controller.
// The state list mirrors the request lifecycle from accept to response.
package cache_pkg;

    localparam int CACHE_ADDR_W = 8;
    localparam int CACHE_DATA_W = 32;
    localparam int CACHE_CNT_W  = 16;

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        CHECK,
        MEM_REQ,
        MEM_WAIT,
        FILL,
        RESP
    } state_t;

endpackage

// File: rtl/cache_line_ctrl_if.sv
// Client, cache-line and backing-memory signals of the controller.
// slave is the controller's view; master is the surrounding environment's view.
interface cache_line_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              resp_valid;
    logic              resp_hit;
    logic [DATA_W-1:0] resp_rdata;
    logic [ADDR_W-1:0] line_addr;
    logic [DATA_W-1:0] line_wval;
    logic              line_read;
    logic              line_write;
    logic              line_hit;
    logic [DATA_W-1:0] line_rval;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_req_write;
    logic [ADDR_W-1:0] mem_req_addr;
    logic [DATA_W-1:0] mem_req_wdata;
    logic              mem_resp_valid;
    logic [DATA_W-1:0] mem_resp_data;

    modport slave (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready, resp_valid, resp_hit, resp_rdata,
        output line_addr, line_wval, line_read, line_write,
        input  line_hit, line_rval,
        output mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        input  mem_req_ready, mem_resp_valid, mem_resp_data
    );

    modport master (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_hit, resp_rdata,
        input  line_addr, line_wval, line_read, line_write,
        output line_hit, line_rval,
        input  mem_req_valid, mem_req_write, mem_req_addr, mem_req_wdata,
        output mem_req_ready, mem_resp_valid, mem_resp_data
    );

endinterface

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
// Count visible one cycle after i_inc; no backpressure.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         i_inc,
    output logic [W-1:0] o_count
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {W{1'b1}})) begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    assign o_count = r_cnt;

endmodule

// File: rtl/cache_line_ctrl.sv
// Single-outstanding requester for a one-entry cache line: read-allocate, write-through.
// Hit 3 cycles, write 4+N, miss adds memory stalls; client held off by req_ready=0 while busy.
module cache_line_ctrl
    import cache_pkg::*;
#(
    parameter int ADDR_W = CACHE_ADDR_W,
    parameter int DATA_W = CACHE_DATA_W,
    parameter int CNT_W  = CACHE_CNT_W
) (
    input  logic             clock,
    input  logic             reset,
    cache_line_ctrl_if.slave bus,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    state_t            r_state;
    state_t            w_next;
    logic              w_accept;
    logic              w_hit_inc;
    logic              w_miss_inc;
    logic              w_resp_hit;
    logic [DATA_W-1:0] w_resp_rdata;

    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_fill_data;
    logic              r_wr_hit;

    logic              r_req_ready;
    logic              r_resp_valid;
    logic              r_resp_hit;
    logic [DATA_W-1:0] r_resp_rdata;
    logic [ADDR_W-1:0] r_line_addr;
    logic [DATA_W-1:0] r_line_wval;
    logic              r_line_read;
    logic              r_line_write;
    logic              r_mem_req_valid;
    logic              r_mem_req_write;
    logic [ADDR_W-1:0] r_mem_req_addr;
    logic [DATA_W-1:0] r_mem_req_wdata;

    assign w_accept = (r_state == IDLE) && bus.req_valid && r_req_ready;

    always_comb begin
        w_next       = r_state;
        w_hit_inc    = 1'b0;
        w_miss_inc   = 1'b0;
        w_resp_hit   = 1'b0;
        w_resp_rdata = '0;
        case (r_state)
            IDLE:     if (w_accept) w_next = LOOKUP;
            LOOKUP:   w_next = CHECK;
            CHECK: begin
                if (!r_write && bus.line_hit) begin
                    w_next       = RESP;
                    w_hit_inc    = 1'b1;
                    w_resp_hit   = 1'b1;
                    w_resp_rdata = bus.line_rval;
                end else begin
                    w_next     = MEM_REQ;
                    w_miss_inc = !r_write;
                end
            end
            MEM_REQ: begin
                if (bus.mem_req_ready) begin
                    w_next     = r_write ? RESP : MEM_WAIT;
                    w_resp_hit = r_wr_hit;
                end
            end
            MEM_WAIT: if (bus.mem_resp_valid) w_next = FILL;
            FILL: begin
                w_next       = RESP;
                w_resp_rdata = r_fill_data;
            end
            RESP:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    // Every output is registered from the next state so it lines up with the state it belongs to.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state         <= IDLE;
            r_req_ready     <= 1'b1;
            r_write         <= 1'b0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_fill_data     <= '0;
            r_wr_hit        <= 1'b0;
            r_resp_valid    <= 1'b0;
            r_resp_hit      <= 1'b0;
            r_resp_rdata    <= '0;
            r_line_addr     <= '0;
            r_line_wval     <= '0;
            r_line_read     <= 1'b0;
            r_line_write    <= 1'b0;
            r_mem_req_valid <= 1'b0;
            r_mem_req_write <= 1'b0;
            r_mem_req_addr  <= '0;
            r_mem_req_wdata <= '0;
        end else begin
            r_state     <= w_next;
            r_req_ready <= (w_next == IDLE);
            if (w_accept) begin
                r_write     <= bus.req_write;
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_line_addr <= bus.req_addr;
                r_line_wval <= bus.req_wdata;
            end
            if (r_state == CHECK) begin
                r_wr_hit        <= bus.line_hit;
                r_mem_req_write <= r_write;
                r_mem_req_addr  <= r_addr;
                r_mem_req_wdata <= r_wdata;
            end
            // Refill data goes to the line (FILL keeps line_addr from LOOKUP) and to the response.
            if ((r_state == MEM_WAIT) && bus.mem_resp_valid) begin
                r_fill_data <= bus.mem_resp_data;
                r_line_wval <= bus.mem_resp_data;
            end
            r_line_read     <= w_accept && !bus.req_write;
            r_line_write    <= (w_accept && bus.req_write) || (w_next == FILL);
            r_mem_req_valid <= (w_next == MEM_REQ);
            r_resp_valid    <= (w_next == RESP);
            r_resp_hit      <= (w_next == RESP) && w_resp_hit;
            r_resp_rdata    <= (w_next == RESP) ? w_resp_rdata : '0;
        end
    end

    assign bus.req_ready     = r_req_ready;
    assign bus.resp_valid    = r_resp_valid;
    assign bus.resp_hit      = r_resp_hit;
    assign bus.resp_rdata    = r_resp_rdata;
    assign bus.line_addr     = r_line_addr;
    assign bus.line_wval     = r_line_wval;
    assign bus.line_read     = r_line_read;
    assign bus.line_write    = r_line_write;
    assign bus.mem_req_valid = r_mem_req_valid;
    assign bus.mem_req_write = r_mem_req_write;
    assign bus.mem_req_addr  = r_mem_req_addr;
    assign bus.mem_req_wdata = r_mem_req_wdata;

    sat_counter #(.W(CNT_W)) u_hit_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_hit_inc),
        .o_count (hit_count)
    );

    sat_counter #(.W(CNT_W)) u_miss_cnt (
        .clock   (clock),
        .reset   (reset),
        .i_inc   (w_miss_inc),
        .o_count (miss_count)
    );

endmodule

// File: tb/tb_cache_line_ctrl.sv
// Directed bench for cache_line_ctrl with a one-entry line model and a stallable memory model.
// Counters are built 4 bits wide so saturation is reachable in a few requests.
module tb_cache_line_ctrl;

    logic       clock;
    logic       reset;
    logic [3:0] hit_count;
    logic [3:0] miss_count;

    cache_line_ctrl_if #(.ADDR_W(8), .DATA_W(32)) bus ();

    cache_line_ctrl #(.ADDR_W(8), .DATA_W(32), .CNT_W(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .bus        (bus),
        .hit_count  (hit_count),
        .miss_count (miss_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Line model: registered outputs, rejects writes to a different address once occupied.
    logic        ln_valid = 1'b0;
    logic [7:0]  ln_tag   = 8'h00;
    logic [31:0] ln_val   = 32'h0;
    always @(posedge clock) begin
        if (bus.line_read) begin
            bus.line_hit  <= ln_valid && (ln_tag == bus.line_addr);
            bus.line_rval <= ln_val;
        end else if (bus.line_write) begin
            if (!ln_valid || (ln_tag == bus.line_addr)) begin
                ln_valid     <= 1'b1;
                ln_tag       <= bus.line_addr;
                ln_val       <= bus.line_wval;
                bus.line_hit <= 1'b1;
            end else begin
                bus.line_hit <= 1'b0;
            end
        end
    end

    // Memory model: ready held low cfg_stall cycles, read data cfg_lat cycles after the handshake.
    int          cfg_stall = 0;
    int          cfg_lat   = 0;
    logic [31:0] mem_arr [256];
    bit          mem_init  = 0;
    bit          s_valid   = 0;
    bit          s_write   = 0;
    logic [7:0]  s_addr    = 8'h0;
    logic [31:0] s_wdata   = 32'h0;
    bit          rd_pend   = 0;
    logic [7:0]  rd_addr   = 8'h0;
    int          stall_cnt = 0;
    int          lat_cnt   = 0;
    logic        model_rv  = 1'b0;
    logic [31:0] model_rd  = 32'h0;
    logic        stray_rv  = 1'b0;
    logic [31:0] stray_rd  = 32'h0;

    assign bus.mem_resp_valid = model_rv | stray_rv;
    assign bus.mem_resp_data  = stray_rv ? stray_rd : model_rd;

    always @(negedge clock) begin
        if (!mem_init) begin
            for (int a = 0; a < 256; a++) mem_arr[a] = 32'hA500_0000 | 32'(a);
            mem_arr[8'h10] = 32'hDEAD_BEEF;
            mem_init = 1;
            bus.mem_req_ready = 1'b0;
        end
        model_rv = 1'b0;
        if (s_valid && bus.mem_req_ready) begin
            if (s_write) begin
                mem_arr[s_addr] = s_wdata;
            end else begin
                rd_pend = 1;
                rd_addr = s_addr;
                lat_cnt = 0;
            end
        end
        if (rd_pend) begin
            if (lat_cnt >= cfg_lat) begin
                model_rv = 1'b1;
                model_rd = mem_arr[rd_addr];
                rd_pend  = 0;
            end else begin
                lat_cnt++;
            end
        end
        if (bus.mem_req_valid) begin
            if (stall_cnt < cfg_stall) begin
                bus.mem_req_ready = 1'b0;
                stall_cnt++;
            end else begin
                bus.mem_req_ready = 1'b1;
            end
        end else begin
            bus.mem_req_ready = 1'b0;
            stall_cnt = 0;
        end
        s_valid = bus.mem_req_valid;
        s_write = bus.mem_req_write;
        s_addr  = bus.mem_req_addr;
        s_wdata = bus.mem_req_wdata;
    end

    typedef struct {
        bit          wr;
        logic [7:0]  addr;
        logic [31:0] wdata;
        int          stall;
        int          lat;
        bit          exp_hit;
        logic [31:0] exp_rdata;
        int          exp_cycles;  // 0 = latency not checked
        int          exp_memc;
        int          exp_lr;
        int          exp_lw;
        logic [3:0]  exp_hc;
        logic [3:0]  exp_mc;
    } vec_t;

    task automatic do_req(input vec_t v, input string tag);
        int w, n, memc, lr, lw, both, mbad, lat;
        bit got, rhit;
        logic [31:0] rdata, lw_val;
        logic [7:0]  lw_addr;
        w = 0; n = 1; memc = 0; lr = 0; lw = 0; both = 0; mbad = 0; lat = 0;
        got = 0; rhit = 0; rdata = 0; lw_val = 0; lw_addr = 0;
        @(negedge clock);
        cfg_stall = v.stall;
        cfg_lat   = v.lat;
        bus.req_valid = 1'b1;
        bus.req_write = v.wr;
        bus.req_addr  = v.addr;
        bus.req_wdata = v.wdata;
        while (!bus.req_ready && w < 20) begin
            @(negedge clock);
            w++;
        end
        chk({tag, "_ready"}, 32'(bus.req_ready), 32'd1);
        @(negedge clock);
        bus.req_valid = 1'b0;
        while (!got && n <= 60) begin
            if (bus.line_read) lr++;
            if (bus.line_write) begin
                lw++;
                lw_addr = bus.line_addr;
                lw_val  = bus.line_wval;
            end
            if (bus.line_read && bus.line_write) both++;
            if (bus.mem_req_valid) begin
                memc++;
                if (bus.mem_req_write !== v.wr || bus.mem_req_addr !== v.addr ||
                    bus.mem_req_wdata !== v.wdata) mbad++;
            end
            if (bus.resp_valid) begin
                got   = 1;
                lat   = n;
                rhit  = bus.resp_hit;
                rdata = bus.resp_rdata;
            end else begin
                @(negedge clock);
                n++;
            end
        end
        chk({tag, "_resp_seen"}, 32'(got), 32'd1);
        chk({tag, "_hit"}, 32'(rhit), 32'(v.exp_hit));
        chk({tag, "_rdata"}, rdata, v.exp_rdata);
        if (v.exp_cycles != 0) chk({tag, "_latency"}, 32'(lat), 32'(v.exp_cycles));
        chk({tag, "_mem_cycles"}, 32'(memc), 32'(v.exp_memc));
        chk({tag, "_mem_fields"}, 32'(mbad), 32'd0);
        chk({tag, "_line_reads"}, 32'(lr), 32'(v.exp_lr));
        chk({tag, "_line_writes"}, 32'(lw), 32'(v.exp_lw));
        chk({tag, "_rd_wr_both"}, 32'(both), 32'd0);
        if (lw > 0) begin
            chk({tag, "_lw_addr"}, 32'(lw_addr), 32'(v.addr));
            chk({tag, "_lw_val"}, lw_val, v.wr ? v.wdata : v.exp_rdata);
        end
        @(negedge clock);
        chk({tag, "_strobe_1cyc"}, 32'(bus.resp_valid), 32'd0);
        chk({tag, "_ready_after"}, 32'(bus.req_ready), 32'd1);
        chk({tag, "_hit_count"}, 32'(hit_count), 32'(v.exp_hc));
        chk({tag, "_miss_count"}, 32'(miss_count), 32'(v.exp_mc));
    endtask

    vec_t vecs[7];

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int rc, mc, lwc, acc, rsp, bad, pulse, nrdy;
        vec_t v;
        //            wr addr   wdata         stl lat hit rdata         cyc memc lr lw hc mc
        vecs[0] = '{0, 8'h10, 32'h0,        0, 2, 0, 32'hDEADBEEF, 0, 1, 1, 1, 4'd0, 4'd1};
        vecs[1] = '{0, 8'h10, 32'h0,        0, 0, 1, 32'hDEADBEEF, 3, 0, 1, 0, 4'd1, 4'd1};
        vecs[2] = '{1, 8'h20, 32'h12345678, 3, 0, 0, 32'h0,        7, 4, 0, 1, 4'd1, 4'd1};
        vecs[3] = '{0, 8'h20, 32'h0,        1, 0, 0, 32'h12345678, 0, 2, 1, 1, 4'd1, 4'd2};
        vecs[4] = '{1, 8'h10, 32'hCAFEF00D, 0, 0, 1, 32'h0,        4, 1, 0, 1, 4'd1, 4'd2};
        vecs[5] = '{0, 8'h10, 32'h0,        0, 0, 1, 32'hCAFEF00D, 3, 0, 1, 0, 4'd2, 4'd2};
        vecs[6] = '{0, 8'h33, 32'h0,        0, 0, 0, 32'hA5000033, 0, 1, 1, 1, 4'd2, 4'd3};

        reset = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(negedge clock);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_mem_req_valid", 32'(bus.mem_req_valid), 32'd0);
        chk("rst_line_rw", {30'd0, bus.line_read, bus.line_write}, 32'd0);
        chk("rst_counts", {24'd0, hit_count, miss_count}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 7; i++) do_req(vecs[i], $sformatf("v%0d", i));

        // Reset while waiting for refill data; the late memory response must be ignored.
        @(negedge clock);
        cfg_stall = 0;
        cfg_lat   = 8;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h44;
        @(negedge clock);
        bus.req_valid = 1'b0;
        rc = 0;
        while (!bus.mem_req_valid && rc < 20) begin @(negedge clock); rc++; end
        while (bus.mem_req_valid && rc < 40) begin @(negedge clock); rc++; end
        chk("rstmid_reached_wait", 32'(rc < 40), 32'd1);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        rc = 0; mc = 0; pulse = 0; nrdy = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clock);
            if (bus.resp_valid) rc++;
            if (bus.mem_req_valid) mc++;
            if (bus.mem_resp_valid) pulse++;
            if (!bus.req_ready) nrdy++;
        end
        chk("rstmid_mem_pulse_seen", 32'(pulse), 32'd1);
        chk("rstmid_no_resp", 32'(rc), 32'd0);
        chk("rstmid_no_mem_req", 32'(mc), 32'd0);
        chk("rstmid_ready_idle", 32'(nrdy), 32'd0);
        chk("rstmid_counts", {24'd0, hit_count, miss_count}, 32'd0);

        // Sixteen read hits on the line (now 0x10/0xCAFEF00D): counter saturates at 0xF.
        for (int i = 0; i < 16; i++) begin
            v = '{0, 8'h10, 32'h0, 0, 0, 1, 32'hCAFEF00D, 3, 0, 1, 0,
                  4'((i + 1 > 15) ? 15 : i + 1), 4'd0};
            do_req(v, $sformatf("sat%0d", i));
        end

        // Stray memory response while idle.
        @(negedge clock);
        stray_rd = 32'hBADBAD00;
        stray_rv = 1'b1;
        @(negedge clock);
        stray_rv = 1'b0;
        rc = 0; mc = 0; lwc = 0; nrdy = 0;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid) rc++;
            if (bus.mem_req_valid) mc++;
            if (bus.line_write) lwc++;
            if (!bus.req_ready) nrdy++;
            @(negedge clock);
        end
        chk("stray_no_resp", 32'(rc), 32'd0);
        chk("stray_no_activity", 32'(mc + lwc), 32'd0);
        chk("stray_still_idle", 32'(nrdy), 32'd0);

        // req_valid held high continuously: one accept per response, every 4 cycles on a hit.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_addr  = 8'h10;
        acc = 0; rsp = 0; bad = 0;
        for (int k = 0; k < 16; k++) begin
            if (bus.resp_valid) rsp++;
            if (bus.req_valid && bus.req_ready) acc++;
            if (acc - rsp > 1 || rsp > acc) bad++;
            @(negedge clock);
        end
        bus.req_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            if (bus.resp_valid) rsp++;
            @(negedge clock);
        end
        chk("held_accepts", 32'(acc), 32'd4);
        chk("held_one_per_resp", 32'(rsp), 32'(acc));
        chk("held_order", 32'(bad), 32'd0);
        chk("held_hit_sat", 32'(hit_count), 32'd15);
        chk("held_miss_count", 32'(miss_count), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
